// File: rtl/aes128_pkg.sv
// Shared types and constants for the AES-128 round controller.
//
// Contents:
//   ctrl_state_e       controller states IDLE, INIT, SUB, KEY, MIX, DONE
//   ctrl_out_t         bundle of the registered single-bit/column controls
//   AES_RCON_INIT      first round constant (8'h01)
//   AES_RCON_POLY      GF(2^8) reduction term applied by xtime (8'h1B)
//   AES128_NUM_ROUNDS  standard AES-128 round count (10)
//   xtime()            multiply-by-x in GF(2^8)
package aes128_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SUB,
    KEY,
    MIX,
    DONE
  } ctrl_state_e;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       load;
    logic       src;
    logic [1:0] col;
    logic       sub;
    logic       key;
    logic       mix;
    logic       last;
  } ctrl_out_t;

  localparam logic [7:0] AES_RCON_INIT     = 8'h01;
  localparam logic [7:0] AES_RCON_POLY     = 8'h1B;
  localparam int         AES128_NUM_ROUNDS = 10;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? AES_RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes128_rcon_gen.sv
// Round-constant register for the AES-128 key schedule.
// Holds Rcon for the current round; clr_i reloads 8'h01, step_i advances
// by one xtime. clr_i has priority over step_i.
//
// Ports:
//   clk     in   system clock
//   rst_n   in   async active-low reset (register returns to 8'h01)
//   clr_i   in   reload the first round constant
//   step_i  in   advance to the next round constant
//   rcon_o  out  current round constant
module aes128_rcon_gen
  import aes128_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       step_i,
  output logic [7:0] rcon_o
);

  logic [7:0] rcon_d, rcon_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    rcon_d = rcon_q;
    if (clr_i) begin
      rcon_d = AES_RCON_INIT;
    end else if (step_i) begin
      rcon_d = xtime(rcon_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcon_q <= AES_RCON_INIT;
    end else begin
      rcon_q <= rcon_d;
    end
  end

  assign rcon_o = rcon_q;

endmodule

// File: rtl/aes128_round_ctrl.sv
// Round sequencer for the AES-128 encrypt datapath. One shared S-box bank is
// time-multiplexed between the state SubBytes columns (SUB cycles) and the
// key-schedule RotWord (KEY cycle). Each round is NSUB SUB cycles, one KEY
// and one MIX; a run is INIT, NUM_ROUNDS rounds, then a one-cycle DONE.
//
// Parameters:
//   NUM_ROUNDS    rounds after the initial AddRoundKey, 1..15
//   COLS_PER_SUB  state columns substituted per SUB cycle, 1, 2 or 4
//
// Ports:
//   clk, rst_n     clock, async active-low reset
//   start_i        begin a run (only honoured in IDLE)
//   abort_i        cancel a run (present only with AES128_CTRL_ABORT_EN)
//   busy_o         high from INIT through the last MIX
//   done_o         one-cycle pulse, ciphertext valid
//   state_load_o   load plaintext ^ key and the cipher key (INIT)
//   sbox_src_o     S-box input select: 0 state columns, 1 rotated key word
//   sbox_col_o     first column substituted this SUB cycle
//   sub_en_o       write S-box result into the state column(s)
//   key_step_en_o  advance the key register to the next round key
//   mix_en_o       ShiftRows / MixColumns / AddRoundKey step
//   last_round_o   final round (datapath skips MixColumns)
//   round_o        current round, 0 outside SUB/KEY/MIX
//   rcon_o         round constant for the current round
//
// Build option: define AES128_CTRL_ABORT_EN to add abort_i. Without it a
// started run always completes.
module aes128_round_ctrl
  import aes128_pkg::*;
#(
  parameter int NUM_ROUNDS   = AES128_NUM_ROUNDS,
  parameter int COLS_PER_SUB = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
`ifdef AES128_CTRL_ABORT_EN
  input  logic       abort_i,
`endif
  output logic       busy_o,
  output logic       done_o,
  output logic       state_load_o,
  output logic       sbox_src_o,
  output logic [1:0] sbox_col_o,
  output logic       sub_en_o,
  output logic       key_step_en_o,
  output logic       mix_en_o,
  output logic       last_round_o,
  output logic [3:0] round_o,
  output logic [7:0] rcon_o
);

  localparam int         NSUB     = 4 / COLS_PER_SUB;
  localparam logic [1:0] LAST_SUB = 2'(NSUB - 1);
  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  ctrl_state_e state_d, state_q;
  logic [3:0]  round_d, round_q;
  logic [1:0]  cnt_d, cnt_q;
  ctrl_out_t   out_d, out_q;
  logic        rcon_clr, rcon_step;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) state_d = INIT;
      end
      INIT: begin
        state_d = SUB;
        round_d = 4'd1;
        cnt_d   = '0;
      end
      SUB: begin
        if (cnt_q == LAST_SUB) begin
          state_d = KEY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      KEY: state_d = MIX;
      MIX: begin
        if (round_q == LAST_RND) begin
          state_d = DONE;
          round_d = '0;
        end else begin
          state_d = SUB;
          round_d = round_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        round_d = '0;
        cnt_d   = '0;
      end
    endcase

`ifdef AES128_CTRL_ABORT_EN
    // Abort overrides everything, including a simultaneous start in IDLE.
    if (abort_i) begin
      state_d = IDLE;
      round_d = '0;
      cnt_d   = '0;
    end
`endif

    // Controls are decoded from the next state so the registered outputs
    // line up with the state they describe, not one cycle behind it.
    out_d      = '0;
    out_d.busy = state_d inside {INIT, SUB, KEY, MIX};
    out_d.done = (state_d == DONE);
    out_d.load = (state_d == INIT);
    out_d.sub  = (state_d == SUB);
    out_d.col  = (state_d == SUB) ? 2'(int'(cnt_d) * COLS_PER_SUB) : 2'd0;
    out_d.src  = (state_d == KEY);
    out_d.key  = (state_d == KEY);
    out_d.mix  = (state_d == MIX);
    out_d.last = out_d.busy && (round_d == LAST_RND);
  end

  // Rcon is 8'h01 whenever no round is in flight and advances only on the
  // MIX -> SUB hand-off, so it always belongs to round_o.
  assign rcon_clr  = state_d inside {IDLE, INIT, DONE};
  assign rcon_step = (state_q == MIX) && (state_d == SUB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  aes128_rcon_gen u_rcon_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (rcon_clr),
    .step_i (rcon_step),
    .rcon_o (rcon_o)
  );

  assign busy_o        = out_q.busy;
  assign done_o        = out_q.done;
  assign state_load_o  = out_q.load;
  assign sbox_src_o    = out_q.src;
  assign sbox_col_o    = out_q.col;
  assign sub_en_o      = out_q.sub;
  assign key_step_en_o = out_q.key;
  assign mix_en_o      = out_q.mix;
  assign last_round_o  = out_q.last;
  assign round_o       = round_q;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Bench for aes128_round_ctrl. Three controllers (COLS_PER_SUB = 1, 2, 4)
// share clock, reset and start. Each has a cycle-by-cycle expected-output
// queue built from the round schedule, plus a behavioural AES-128 datapath
// driven by the controller's enables whose ciphertext is compared with a
// straight-line AES reference at every done_o.
module tb_aes128_round_ctrl;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       load;
    logic       src;
    logic [1:0] col;
    logic       sub;
    logic       key;
    logic       mix;
    logic       last;
    logic [3:0] rnd;
    logic [7:0] rc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
`ifdef AES128_CTRL_ABORT_EN
  logic         abort_i;
`endif
  logic [127:0] key_in, pt_in;
  int           cyc = 0;
  int           n_chk = 0;
  int           n_pass = 0;
  logic [7:0]   sbox_t [256];
  logic [7:0]   rc_t [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic busy, done, load, src, input logic [1:0] col,
                              input logic sub, key, mix, last,
                              input logic [3:0] rnd, input logic [7:0] rc);
    exp_t e;
    e.busy = busy; e.done = done; e.load = load; e.src = src; e.col = col;
    e.sub = sub; e.key = key; e.mix = mix; e.last = last; e.rnd = rnd; e.rc = rc;
    return e;
  endfunction

  localparam exp_t IDLE_E = '{busy: 1'b0, done: 1'b0, load: 1'b0, src: 1'b0, col: 2'd0,
                              sub: 1'b0, key: 1'b0, mix: 1'b0, last: 1'b0, rnd: 4'd0,
                              rc: 8'h01};

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sb(input logic [127:0] v, input int i, input logic [7:0] x);
    logic [127:0] r = v;
    r[127-8*i -: 8] = x;
    return r;
  endfunction

  function automatic logic [127:0] sub_cols(input logic [127:0] v, input int first, input int n);
    logic [127:0] r = v;
    for (int j = 0; j < n; j++)
      for (int b = 0; b < 4; b++)
        r = sb(r, 4*((first + j) % 4) + b, sbox_t[gb(r, 4*((first + j) % 4) + b)]);
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] v);
    logic [127:0] r = v;
    for (int c = 0; c < 4; c++)
      for (int b = 0; b < 4; b++)
        r = sb(r, 4*c + b, gb(v, 4*((c + b) % 4) + b));
    return r;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] v);
    logic [127:0] r = v;
    logic [7:0]   a [4];
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < 4; b++) a[b] = gb(v, 4*c + b);
      for (int b = 0; b < 4; b++)
        r = sb(r, 4*c + b, gmul(a[b], 8'h02) ^ gmul(a[(b+1)%4], 8'h03) ^
                           a[(b+2)%4] ^ a[(b+3)%4]);
    end
    return r;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox_t[gb(k, 13)], sbox_t[gb(k, 14)], sbox_t[gb(k, 15)], sbox_t[gb(k, 12)]}
         ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] mix_step(input logic [127:0] s, input logic [127:0] k,
                                            input logic last);
    logic [127:0] r = shift_rows(s);
    if (!last) r = mix_cols(r);
    return r ^ k;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s = pt ^ key;
    logic [127:0] k = key;
    logic [7:0]   rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      s  = sub_cols(s, 0, 4);
      k  = key_next(k, rc);
      s  = mix_step(s, k, r == 10);
      rc = gmul(rc, 8'h02);
    end
    return s;
  endfunction

  // ---------------- three controller configurations ----------------
  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int C     = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    localparam int NS    = 4 / C;
    localparam int LAT   = (g == 0) ? 61 : (g == 1) ? 41 : 31;
    localparam int NSUBT = (g == 0) ? 40 : (g == 1) ? 20 : 10;

    logic         busy, done, load, src, sub, key, mix, last;
    logic [1:0]   col;
    logic [3:0]   rnd;
    logic [7:0]   rc;
    exp_t         act;
    exp_t         cur = IDLE_E;
    exp_t         q[$];
    logic [127:0] st, kr, ct_exp;
    logic [79:0]  trace;
    int           n_sub, n_key, n_mix, cyc_load;

    aes128_round_ctrl #(.NUM_ROUNDS(10), .COLS_PER_SUB(C)) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
`ifdef AES128_CTRL_ABORT_EN
      .abort_i       (abort_i),
`endif
      .busy_o        (busy),
      .done_o        (done),
      .state_load_o  (load),
      .sbox_src_o    (src),
      .sbox_col_o    (col),
      .sub_en_o      (sub),
      .key_step_en_o (key),
      .mix_en_o      (mix),
      .last_round_o  (last),
      .round_o       (rnd),
      .rcon_o        (rc)
    );

    assign act = {busy, done, load, src, col, sub, key, mix, last, rnd, rc};

    // One accepted start expands into the full per-cycle schedule of the run.
    function automatic void push_run();
      q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h01));
      for (int r = 1; r <= 10; r++) begin
        for (int s = 0; s < NS; s++)
          q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'(s * C), 1'b1, 1'b0, 1'b0,
                         r == 10, 4'(r), rc_t[r-1]));
        q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0,
                       r == 10, 4'(r), rc_t[r-1]));
        q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1,
                       r == 10, 4'(r), rc_t[r-1]));
      end
      q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h01));
    endfunction

    // Reference model: advances one cycle per clock edge.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        cur <= IDLE_E;
      end else begin
`ifdef AES128_CTRL_ABORT_EN
        if (abort_i) begin
          q.delete();
          cur <= IDLE_E;
        end else begin
`endif
          if (cur == IDLE_E && start_i) push_run();
          cur <= (q.size() != 0) ? q.pop_front() : IDLE_E;
`ifdef AES128_CTRL_ABORT_EN
        end
`endif
      end
    end

    // Compare process: every output, every cycle, against the model.
    always @(negedge clk) begin
      check($sformatf("cols%0d outputs @%0d", C, cyc), 128'(act), 128'(cur));
    end

    // Behavioural datapath driven by the enables, with per-run bookkeeping.
    always @(negedge clk) begin
      if (rst_n) begin
        if (load) begin
          st       <= pt_in ^ key_in;
          kr       <= key_in;
          ct_exp   <= aes_ref(key_in, pt_in);
          n_sub    <= 0;
          n_key    <= 0;
          n_mix    <= 0;
          trace    <= '0;
          cyc_load <= cyc;
        end
        if (sub) begin
          st    <= sub_cols(st, int'(col), C);
          n_sub <= n_sub + 1;
        end
        if (key) begin
          kr    <= key_next(kr, rc);
          n_key <= n_key + 1;
          trace <= {trace[71:0], rc};
        end
        if (mix) begin
          st    <= mix_step(st, kr, last);
          n_mix <= n_mix + 1;
        end
        if (done) begin
          check($sformatf("cols%0d ciphertext", C), st, ct_exp);
          check($sformatf("cols%0d latency", C), 128'(cyc - cyc_load), 128'(LAT));
          check($sformatf("cols%0d sub_en count", C), 128'(n_sub), 128'(NSUBT));
          check($sformatf("cols%0d key_step count", C), 128'(n_key), 128'(10));
          check($sformatf("cols%0d mix count", C), 128'(n_mix), 128'(10));
          check($sformatf("cols%0d rcon trace", C), 128'(trace),
                128'(80'h01020408102040801b36));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input int len);
    start_i = 1'b1;
    repeat (len) tick();
    start_i = 1'b0;
  endtask

  task automatic wait_all_idle(input int budget);
    int n = 0;
    tick();
    tick();
    while (n < budget &&
           (g_cfg[0].busy || g_cfg[0].done || g_cfg[1].busy || g_cfg[1].done ||
            g_cfg[2].busy || g_cfg[2].done)) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      n_chk++;
      $display("FAIL idle wait: controllers still active after %0d cycles, required idle", n);
    end
  endtask

  initial begin
    logic [7:0] inv;
    rst_n   = 1'b0;
    start_i = 1'b0;
`ifdef AES128_CTRL_ABORT_EN
    abort_i = 1'b0;
`endif
    key_in  = 128'h000102030405060708090a0b0c0d0e0f;
    pt_in   = 128'h00112233445566778899aabbccddeeff;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    // Reset values.
    repeat (3) tick();
    check("reset busy_o", 128'(g_cfg[0].busy), 128'd0);
    check("reset done_o", 128'(g_cfg[0].done), 128'd0);
    check("reset round_o", 128'(g_cfg[0].rnd), 128'd0);
    check("reset rcon_o", 128'(g_cfg[0].rc), 128'h01);
    rst_n = 1'b1;
    repeat (20) tick();

    // FIPS-197 vector through all three configurations.
    pulse_start(1);
    wait_all_idle(200);
    check("cols1 FIPS ct", g_cfg[0].st, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("cols2 FIPS ct", g_cfg[1].st, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("cols4 FIPS ct", g_cfg[2].st, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

    // start held high: one run per IDLE visit.
    start_i = 1'b1;
    repeat (150) tick();
    start_i = 1'b0;
    wait_all_idle(200);

    // Reset in round 5, then a fresh run.
    pulse_start(1);
    repeat (29) tick();
    rst_n = 1'b0;
    #1;
    check("mid-run reset busy_o", 128'(g_cfg[0].busy), 128'd0);
    check("mid-run reset round_o", 128'(g_cfg[0].rnd), 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start(1);
    wait_all_idle(200);

`ifdef AES128_CTRL_ABORT_EN
    pulse_start(1);
    repeat (29) tick();
    abort_i = 1'b1;
    start_i = 1'b1;
    tick();
    abort_i = 1'b0;
    start_i = 1'b0;
    tick();
    check("abort busy_o", 128'(g_cfg[0].busy), 128'd0);
    pulse_start(1);
    wait_all_idle(200);
`endif

    // Randomised runs: gaps, start lengths, keys, plaintexts, cancellations.
    for (int it = 0; it < 25; it++) begin
      int mode;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      pt_in  = {$urandom, $urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 4)) tick();
      pulse_start($urandom_range(1, 3));
      mode = $urandom_range(0, 5);
      if (mode == 0) begin
        repeat ($urandom_range(1, 60)) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
`ifdef AES128_CTRL_ABORT_EN
      else if (mode == 1) begin
        repeat ($urandom_range(1, 60)) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
      end
`endif
      wait_all_idle(200);
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
